// File: rtl/rv32ima_pkg.sv
// rtl/rv32ima_pkg.sv - shared types and encodings for the RV32 memory responder
//
// Purpose: responder FSM state type and data-access width encodings.

package rv32ima_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWAIT = 2'd1,
    ST_IWAIT = 2'd2,
    ST_DONE  = 2'd3
  } memresp_state_t;

  // dmem_width encodings; 2'b11 falls through to word handling.
  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering and misalign detection
//
// Purpose: combinational lane logic for byte/half/word accesses.
// Ports:
//   offset     in  2  : byte offset within the word (addr[1:0])
//   width      in  2  : access size (MEM_BYTE / MEM_HALF / word)
//   store_data in  32 : right-aligned store value
//   read_data  in  32 : raw RAM word
//   be         out 4  : byte enables
//   wdata      out 32 : lane-replicated write data
//   load_data  out 32 : right-aligned, zero-extended load value
//   misalign   out 1  : half at odd offset or word at nonzero offset

module mem_lane_align
  import rv32ima_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  width,
  input  logic [31:0] store_data,
  input  logic [31:0] read_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [31:0] shifted;

  always_comb begin
    shifted   = read_data >> {offset, 3'b000};
    be        = 4'b1111;
    wdata     = store_data;
    load_data = shifted;
    misalign  = 1'b0;
    case (width)
      MEM_BYTE: begin
        be        = 4'b0001 << offset;
        wdata     = {4{store_data[7:0]}};
        load_data = {24'b0, shifted[7:0]};
      end
      MEM_HALF: begin
        be        = 4'b0011 << offset;
        wdata     = {2{store_data[15:0]}};
        load_data = {16'b0, shifted[15:0]};
        misalign  = offset[0];
      end
      default: begin
        misalign  = (offset != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - shared-RAM responder for the RV32 fetch and data ports
//
// Purpose: serves instruction and data requests from one single-port RAM,
// data first, with a one-cycle hit pulse per access.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   imem_ren/imem_addr             : fetch request and byte address
//   ihit/imem_load                 : fetch completion pulse and word
//   dmem_ren/dmem_wen/dmem_addr    : data load/store request and byte address
//   dmem_width/dmem_store          : access size and right-aligned store data
//   dhit/dmem_load/dmem_fault      : data completion pulse, load value, misalign
//   ram_req/ram_we/ram_addr/ram_be/ram_wdata : registered RAM request fields
//   ram_rdata/ram_ack              : RAM read data and completion

module mem_responder
  import rv32ima_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int WORD_ADDR_W = 30
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   imem_ren,
  input  logic [ADDR_W-1:0]      imem_addr,
  output logic                   ihit,
  output logic [31:0]            imem_load,
  input  logic                   dmem_ren,
  input  logic                   dmem_wen,
  input  logic [ADDR_W-1:0]      dmem_addr,
  input  logic [1:0]             dmem_width,
  input  logic [31:0]            dmem_store,
  output logic                   dhit,
  output logic [31:0]            dmem_load,
  output logic                   dmem_fault,
  output logic                   ram_req,
  output logic                   ram_we,
  output logic [WORD_ADDR_W-1:0] ram_addr,
  output logic [3:0]             ram_be,
  output logic [31:0]            ram_wdata,
  input  logic [31:0]            ram_rdata,
  input  logic                   ram_ack
);

  memresp_state_t state, state_next;
  logic           just_done;    // forces the idle gap after each hit
  logic           served_data;  // the access in flight belongs to the data port
  logic [1:0]     lat_off;
  logic [1:0]     lat_width;

  logic           dreq;
  logic [1:0]     lane_off;
  logic [1:0]     lane_width;
  logic [3:0]     lane_be;
  logic [31:0]    lane_wdata;
  logic [31:0]    lane_load;
  logic           lane_misalign;
  logic           unused_fetch_off;

  assign dreq             = dmem_ren | dmem_wen;
  assign unused_fetch_off = ^imem_addr[1:0];

  // In IDLE the lane logic looks at the live request; afterwards it uses
  // the latched fields so read extraction ignores mid-access input changes.
  assign lane_off   = (state == ST_IDLE) ? dmem_addr[1:0] : lat_off;
  assign lane_width = (state == ST_IDLE) ? dmem_width     : lat_width;

  mem_lane_align u_lane (
    .offset     (lane_off),
    .width      (lane_width),
    .store_data (dmem_store),
    .read_data  (ram_rdata),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .load_data  (lane_load),
    .misalign   (lane_misalign)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      just_done <= 1'b0;
    end else begin
      state     <= state_next;
      just_done <= (state == ST_DONE);
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (!just_done) begin
          if (dreq)          state_next = lane_misalign ? ST_DONE : ST_DWAIT;
          else if (imem_ren) state_next = ST_IWAIT;
        end
      end
      ST_DWAIT, ST_IWAIT: begin
        if (ram_ack) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    ihit = 1'b0;
    dhit = 1'b0;
    if (state == ST_DONE) begin
      dhit = served_data;
      ihit = !served_data;
    end
  end

  // Request fields and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_req     <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_be      <= '0;
      ram_wdata   <= '0;
      served_data <= 1'b0;
      lat_off     <= '0;
      lat_width   <= '0;
      dmem_fault  <= 1'b0;
      imem_load   <= '0;
      dmem_load   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!just_done) begin
            if (dreq) begin
              served_data <= 1'b1;
              lat_off     <= dmem_addr[1:0];
              lat_width   <= dmem_width;
              dmem_fault  <= lane_misalign;
              if (lane_misalign) begin
                dmem_load <= '0;
              end else begin
                ram_req   <= 1'b1;
                ram_we    <= dmem_wen;
                ram_addr  <= dmem_addr[ADDR_W-1:2];
                ram_be    <= lane_be;
                ram_wdata <= lane_wdata;
              end
            end else if (imem_ren) begin
              served_data <= 1'b0;
              ram_req     <= 1'b1;
              ram_we      <= 1'b0;
              ram_addr    <= imem_addr[ADDR_W-1:2];
              ram_be      <= 4'b1111;
              ram_wdata   <= '0;
            end
          end
        end
        ST_DWAIT: begin
          if (ram_ack) begin
            ram_req <= 1'b0;
            if (!ram_we) dmem_load <= lane_load;
          end
        end
        ST_IWAIT: begin
          if (ram_ack) begin
            ram_req   <= 1'b0;
            imem_load <= ram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder

module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_ren;
  logic [31:0] imem_addr;
  logic        ihit;
  logic [31:0] imem_load;
  logic        dmem_ren;
  logic        dmem_wen;
  logic [31:0] dmem_addr;
  logic [1:0]  dmem_width;
  logic [31:0] dmem_store;
  logic        dhit;
  logic [31:0] dmem_load;
  logic        dmem_fault;
  logic        ram_req;
  logic        ram_we;
  logic [29:0] ram_addr;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ack;

  int n_checks = 0;
  int n_fail   = 0;

  // RAM model controls and activity counters
  int          ack_delay   = 0;
  logic [31:0] rd_value    = 32'h0;
  logic        force_ack   = 1'b0;
  int          req_cycles  = 0;
  int          req_rises   = 0;
  int          dhit_count  = 0;
  int          ihit_count  = 0;

  mem_responder #(.ADDR_W(32), .WORD_ADDR_W(30)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_ren   (imem_ren),
    .imem_addr  (imem_addr),
    .ihit       (ihit),
    .imem_load  (imem_load),
    .dmem_ren   (dmem_ren),
    .dmem_wen   (dmem_wen),
    .dmem_addr  (dmem_addr),
    .dmem_width (dmem_width),
    .dmem_store (dmem_store),
    .dhit       (dhit),
    .dmem_load  (dmem_load),
    .dmem_fault (dmem_fault),
    .ram_req    (ram_req),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_be     (ram_be),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .ram_ack    (ram_ack)
  );

  always #5 clk = ~clk;

  // RAM model: acks in the (ack_delay+1)-th cycle of a request burst.
  always @(posedge clk) begin
    #1;
    if (ram_req === 1'b1) begin
      ram_ack = (req_cycles == ack_delay) || force_ack;
      req_cycles++;
      if (req_cycles == 1) req_rises++;
    end else begin
      ram_ack    = force_ack;
      req_cycles = 0;
    end
    ram_rdata = rd_value;
    if (dhit === 1'b1) dhit_count++;
    if (ihit === 1'b1) ihit_count++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drop_all();
    imem_ren = 1'b0;
    dmem_ren = 1'b0;
    dmem_wen = 1'b0;
    tick(); tick(); tick();
  endtask

  int  rises0, d0, i0, req_seen;
  bit  got, stable_ok, d_first;

  initial begin
    rst = 1'b1; imem_ren = 1'b0; imem_addr = '0; dmem_ren = 1'b0; dmem_wen = 1'b0;
    dmem_addr = '0; dmem_width = 2'b10; dmem_store = '0; ram_rdata = '0; ram_ack = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_ram_req",   32'(ram_req),    32'h0);
    chk("rst_ram_we",    32'(ram_we),     32'h0);
    chk("rst_ram_be",    32'(ram_be),     32'h0);
    chk("rst_ram_addr",  32'(ram_addr),   32'h0);
    chk("rst_ram_wdata", ram_wdata,       32'h0);
    chk("rst_hits",      {30'b0, ihit, dhit}, 32'h0);
    chk("rst_fault",     32'(dmem_fault), 32'h0);
    chk("rst_loads",     imem_load | dmem_load, 32'h0);
    rst = 1'b0;
    tick(); tick();

    // Fetch only, same-cycle ack
    ack_delay = 0; rd_value = 32'h0000_0013;
    imem_ren = 1'b1; imem_addr = 32'h100;
    tick();
    chk("fetch_req",  32'(ram_req),  32'h1);
    chk("fetch_addr", 32'(ram_addr), 32'h40);
    chk("fetch_be",   32'(ram_be),   32'hf);
    chk("fetch_we",   32'(ram_we),   32'h0);
    chk("fetch_nohit_n1", 32'(ihit), 32'h0);
    tick();
    chk("fetch_ihit", 32'(ihit), 32'h1);
    chk("fetch_load", imem_load, 32'h0000_0013);
    chk("fetch_dhit", 32'(dhit), 32'h0);
    imem_ren = 1'b0;
    tick();
    chk("fetch_pulse", 32'(ihit), 32'h0);
    drop_all();

    // Byte store 0xAB at 0x203
    dmem_wen = 1'b1; dmem_addr = 32'h203; dmem_width = 2'b00; dmem_store = 32'h0000_00AB;
    tick();
    chk("sb_we",    32'(ram_we),   32'h1);
    chk("sb_be",    32'(ram_be),   32'h8);
    chk("sb_wdata", ram_wdata,     32'hABAB_ABAB);
    chk("sb_addr",  32'(ram_addr), 32'h80);
    tick();
    chk("sb_dhit",  32'(dhit),     32'h1);
    chk("sb_fault", 32'(dmem_fault), 32'h0);
    drop_all();

    // Byte load at 0x203
    rd_value = 32'hAB00_0000;
    dmem_ren = 1'b1; dmem_addr = 32'h203; dmem_width = 2'b00;
    tick();
    chk("lb_we", 32'(ram_we), 32'h0);
    chk("lb_be", 32'(ram_be), 32'h8);
    tick();
    chk("lb_dhit", 32'(dhit), 32'h1);
    chk("lb_load", dmem_load, 32'h0000_00AB);
    drop_all();

    // Half load at 0x102
    rd_value = 32'hBEEF_1234;
    dmem_ren = 1'b1; dmem_addr = 32'h102; dmem_width = 2'b01;
    tick();
    chk("lh_be", 32'(ram_be), 32'hc);
    tick();
    chk("lh_load", dmem_load, 32'h0000_BEEF);
    drop_all();

    // Half store at 0x2 with both ren and wen high -> write
    dmem_ren = 1'b1; dmem_wen = 1'b1; dmem_addr = 32'h2; dmem_width = 2'b01; dmem_store = 32'hFFFF_1234;
    tick();
    chk("sh_we",    32'(ram_we),  32'h1);
    chk("sh_be",    32'(ram_be),  32'hc);
    chk("sh_wdata", ram_wdata,    32'h1234_1234);
    tick();
    chk("sh_dhit",  32'(dhit),    32'h1);
    drop_all();

    // Contention: data and fetch in the same cycle
    rises0 = req_rises; d0 = dhit_count; i0 = ihit_count;
    rd_value = 32'h1111_2222;
    dmem_ren = 1'b1; dmem_addr = 32'h300; dmem_width = 2'b10;
    imem_ren = 1'b1; imem_addr = 32'h104;
    tick();
    chk("cont_first_addr", 32'(ram_addr), 32'hc0);
    chk("cont_first_we",   32'(ram_we),   32'h0);
    tick();
    d_first = (dhit === 1'b1) && (ihit === 1'b0);
    chk("cont_dhit_first", 32'(d_first), 32'h1);
    chk("cont_dload",      dmem_load,    32'h1111_2222);
    dmem_ren = 1'b0; rd_value = 32'h3333_4444;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (ihit === 1'b1) got = 1'b1;
    end
    chk("cont_ihit_seen", 32'(got), 32'h1);
    chk("cont_iload",     imem_load, 32'h3333_4444);
    drop_all();
    chk("cont_req_bursts", 32'(req_rises - rises0), 32'h2);
    chk("cont_dhits",      32'(dhit_count - d0),    32'h1);
    chk("cont_ihits",      32'(ihit_count - i0),    32'h1);

    // Misaligned word load at 0x102
    rises0 = req_rises;
    dmem_ren = 1'b1; dmem_addr = 32'h102; dmem_width = 2'b10;
    tick();
    chk("mis_dhit",  32'(dhit),       32'h1);
    chk("mis_fault", 32'(dmem_fault), 32'h1);
    chk("mis_load",  dmem_load,       32'h0);
    chk("mis_req",   32'(ram_req),    32'h0);
    drop_all();
    chk("mis_no_burst", 32'(req_rises - rises0), 32'h0);

    // Slow RAM: ack 5 cycles late, inputs disturbed mid-access
    d0 = dhit_count;
    ack_delay = 5; rd_value = 32'hCAFE_F00D;
    dmem_ren = 1'b1; dmem_addr = 32'h400; dmem_width = 2'b10;
    tick();
    dmem_addr = 32'h7fc; dmem_width = 2'b00;
    req_seen = 0; stable_ok = 1'b1; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (dhit === 1'b1) begin
        got = 1'b1;
      end else begin
        if (ram_req === 1'b1) begin
          req_seen++;
          if (ram_addr !== 30'h100 || ram_be !== 4'hf || ram_we !== 1'b0) stable_ok = 1'b0;
        end
        tick();
      end
    end
    chk("slow_hit_seen", 32'(got),       32'h1);
    chk("slow_stable",   32'(stable_ok), 32'h1);
    chk("slow_req_len",  32'(req_seen),  32'h6);
    chk("slow_load",     dmem_load,      32'hCAFE_F00D);
    chk("slow_fault",    32'(dmem_fault), 32'h0);
    drop_all();
    chk("slow_one_dhit", 32'(dhit_count - d0), 32'h1);

    // Reset during DWAIT, then a stray ack in IDLE
    ack_delay = 10;
    dmem_wen = 1'b1; dmem_addr = 32'h500; dmem_width = 2'b10; dmem_store = 32'h1234_5678;
    tick();
    chk("rma_req_on", 32'(ram_req), 32'h1);
    rst = 1'b1;
    tick();
    chk("rma_req_off", 32'(ram_req), 32'h0);
    chk("rma_no_dhit", 32'(dhit),    32'h0);
    rst = 1'b0; dmem_wen = 1'b0;
    d0 = dhit_count; i0 = ihit_count;
    force_ack = 1'b1;
    tick(); tick();
    force_ack = 1'b0;
    tick(); tick(); tick();
    chk("stray_no_hits", 32'((dhit_count - d0) + (ihit_count - i0)), 32'h0);
    chk("stray_no_req",  32'(ram_req), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
